// File: rtl/led_array_ctrl.sv
// led_array_ctrl: CHANNELS independent LED drivers (OFF/ON/BLINK/PULSE) sharing a prescaled tick.
// Latency: q reflects an accepted command one clock after the accepting edge; pulse_done is a 1-clock strobe.
// Backpressure: none; s_axis_tready is held at 1 from the first clock after reset, one command per clock.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   s_axis_tdata[31:0]  command: [PERIOD_W-1:0] period, [17:16] mode, [23:20] duty, [31:24] channel
//   s_axis_tvalid/ready command handshake (accept = tvalid & tready)
//   q[CHANNELS]         LED outputs, active high
//   pulse_done[CHANNELS] one-clock strobe when a PULSE runs to completion
//
// Optional feature macro: LED_ARRAY_PWM_EN adds a 4-bit PWM brightness gate driven by duty.
module led_array_ctrl #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int CHANNELS    = 4,
  parameter int PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] pulse_done
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  // Handshake: ready rises on the first clock after reset release and stays there.
  logic r_tready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tready <= 1'b0;
    else        r_tready <= 1'b1;
  end
  assign s_axis_tready = r_tready;

  // Shared timebase; commands never disturb its phase.
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  assign w_tick = (r_pre == PRE_W'(DIV - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + PRE_W'(1);
  end

  // Command decode.
  logic                w_acc;
  logic [7:0]          w_cmd_ch;
  mode_e               w_cmd_mode;
  logic [PERIOD_W-1:0] w_cmd_raw;
  logic [PERIOD_W-1:0] w_cmd_period;
  logic                w_unused;

  assign w_acc        = s_axis_tvalid & r_tready;
  assign w_cmd_ch     = s_axis_tdata[31:24];
  assign w_cmd_mode   = mode_e'(s_axis_tdata[17:16]);
  assign w_cmd_raw    = s_axis_tdata[PERIOD_W-1:0];
  // A zero period would make count == period-1 unreachable; treat it as 1.
  assign w_cmd_period = (w_cmd_raw == '0) ? PERIOD_W'(1) : w_cmd_raw;
  // Reserved/ignored command bits are folded here so they are visibly intentional.
  assign w_unused     = ^s_axis_tdata;

`ifdef LED_ARRAY_PWM_EN
  logic [3:0] r_pwm;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= 4'd0;
    else        r_pwm <= r_pwm + 4'd1;
  end
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_e               r_mode;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_count;
    logic                r_state;
    logic                r_pd;
    logic                w_hit;
    logic                w_last;

    // Out-of-range indices match no channel, so they are accepted and dropped.
    assign w_hit  = w_acc && (w_cmd_ch == 8'(g));
    assign w_last = (r_count == (r_period - PERIOD_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode   <= MODE_OFF;
        r_period <= PERIOD_W'(1);
        r_count  <= '0;
        r_state  <= 1'b0;
        r_pd     <= 1'b0;
      end else begin
        r_pd <= 1'b0;
        if (w_hit) begin
          // A command always wins over a coincident tick and restarts the channel.
          r_mode   <= w_cmd_mode;
          r_period <= w_cmd_period;
          r_count  <= '0;
          r_state  <= (w_cmd_mode != MODE_OFF);
        end else if (w_tick) begin
          case (r_mode)
            MODE_BLINK: begin
              if (w_last) begin
                r_state <= ~r_state;
                r_count <= '0;
              end else begin
                r_count <= r_count + PERIOD_W'(1);
              end
            end
            MODE_PULSE: begin
              if (w_last) begin
                r_state <= 1'b0;
                r_mode  <= MODE_OFF;
                r_pd    <= 1'b1;
              end else begin
                r_count <= r_count + PERIOD_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign pulse_done[g] = r_pd;

`ifdef LED_ARRAY_PWM_EN
    logic [3:0] r_duty;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_duty <= 4'd15;
      else if (w_hit) r_duty <= s_axis_tdata[23:20];
    end
    // duty 15 keeps the LED fully on; duty 0 lights it 1 clock in 16.
    assign q[g] = r_state & (r_pwm <= r_duty);
`else
    assign q[g] = r_state;
`endif
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// tb_led_array_ctrl: directed plus randomized check of led_array_ctrl against a tick-counting model.
// Latency: model expectations are compared every clock at the falling edge.
// Backpressure: the DUT never stalls; stimulus drives tvalid freely.
module tb_led_array_ctrl;
  localparam int CLK_FREQ_HZ = 100;
  localparam int TICK_HZ     = 10;
  localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;
  localparam int CH          = 4;
  localparam int PW          = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [CH-1:0] q;
  logic [CH-1:0] pd;

  always #5 clk = ~clk;

  led_array_ctrl #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ    (TICK_HZ),
    .CHANNELS   (CH),
    .PERIOD_W   (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .q            (q),
    .pulse_done   (pd)
  );

  int tests = 0;
  int fails = 0;

  // Model: each channel remembers how many ticks have elapsed since its last command;
  // outputs are derived from that elapsed count arithmetically.
  int ecnt;               // rising edges since reset release
  int m_mode [CH];        // 0 off, 1 on, 2 blink, 3 pulse
  int m_per  [CH];
  int m_t    [CH];        // ticks elapsed since command
  int m_duty [CH];
  logic [CH-1:0] m_pd;
  int pdcnt  [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt = 0;
      m_pd = '0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 0; m_per[i] = 1; m_t[i] = 0; m_duty[i] = 15;
      end
    end else begin
      bit tick;
      bit acc;
      int ch;
      tick = (ecnt % DIV) == DIV - 1;
      acc  = tvalid && (ecnt >= 1);
      ch   = int'(tdata[31:24]);
      m_pd = '0;
      for (int i = 0; i < CH; i++) begin
        if (acc && ch == i) begin
          m_mode[i] = int'(tdata[17:16]);
          m_per[i]  = (tdata[PW-1:0] == 0) ? 1 : int'(tdata[PW-1:0]);
          m_duty[i] = int'(tdata[23:20]);
          m_t[i]    = 0;
        end else if (tick && (m_mode[i] == 2 || m_mode[i] == 3)) begin
          m_t[i]++;
          if (m_mode[i] == 3 && m_t[i] == m_per[i]) begin
            m_pd[i]   = 1'b1;
            m_mode[i] = 0;
          end
        end
      end
      ecnt++;
    end
  end

  function automatic logic [CH-1:0] exp_q();
    logic [CH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      case (m_mode[i])
        1:       r[i] = 1'b1;
        2:       r[i] = ((m_t[i] / m_per[i]) % 2) == 0;
        3:       r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
`ifdef LED_ARRAY_PWM_EN
      r[i] = r[i] & ((ecnt % 16) <= m_duty[i]);
`endif
    end
    return r;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [CH-1:0] eq;
      logic          er;
      eq = exp_q();
      er = (ecnt >= 1);
      tests++;
      if (q !== eq || pd !== m_pd || tready !== er) begin
        fails++;
        $display("FAIL model t=%0t q=%b/%b pulse_done=%b/%b tready=%b/%b (got/expected)",
                 $time, q, eq, pd, m_pd, tready, er);
      end
      for (int i = 0; i < CH; i++) if (pd[i] === 1'b1) pdcnt[i]++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cmd(input int ch, input int mode, input int per, input int duty);
    logic [7:0] c8;
    logic [3:0] d4;
    logic [1:0] m2;
    logic [7:0] p8;
    c8 = ch[7:0]; d4 = duty[3:0]; m2 = mode[1:0]; p8 = per[7:0];
    return {c8, d4, 2'b00, m2, 8'h00, p8};
  endfunction

  task automatic send(input logic [31:0] c);
    tvalid = 1'b1;
    tdata  = c;
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  // Accept on an edge where the prescaler is at 0: first tick comes 9 clocks later.
  task automatic send_ph(input logic [31:0] c);
    while ((ecnt % DIV) != 0) @(negedge clk);
    send(c);
  endtask

  // Count clocks for which q[ch] stays at lvl, starting at the current falling edge.
  task automatic run(input int ch, input logic lvl, input int exp, input string nm);
    int n;
    n = 0;
    while (q[ch] === lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp);
  endtask

  initial begin
    int base;
    for (int i = 0; i < CH; i++) pdcnt[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_pulse_done", int'(pd), 0);
    chk("rst_tready", int'(tready), 0);

    // A command held across release must not be taken while tready is still 0.
    tvalid = 1'b1;
    tdata  = cmd(0, 1, 5, 15);
    #2 rst_n = 1'b1;
    #1 chk("tready_at_release", int'(tready), 0);
    @(negedge clk);
    chk("tready_first_clk", int'(tready), 1);
    tvalid = 1'b0;
    @(negedge clk);
    chk("no_accept_before_ready", int'(q), 0);

    send(cmd(1, 1, 1, 15));
    chk("ch1_on", int'(q), 4'b0010);
    send(cmd(1, 0, 1, 15));
    chk("ch1_off", int'(q), 0);

    send(cmd(7, 1, 1, 15));
    chk("ch7_ignored", int'(q), 0);
    @(negedge clk);
    chk("ch7_ignored_2", int'(q), 0);

    // BLINK period 3: first high run is 29 clocks due to tick phase, then 30/30.
    send_ph(cmd(0, 2, 3, 15));
    run(0, 1'b1, 29, "blink_high0");
    run(0, 1'b0, 30, "blink_low1");
    run(0, 1'b1, 30, "blink_high1");
    run(0, 1'b0, 30, "blink_low2");
    run(0, 1'b1, 30, "blink_high2");

    // PULSE period 5: high 9 + 4*10 clocks, one strobe on the falling edge.
    base = pdcnt[2];
    send_ph(cmd(2, 3, 5, 15));
    run(2, 1'b1, 49, "pulse5_len");
    chk("pulse5_strobe", int'(pd), 4'b0100);
    @(negedge clk);
    chk("pulse5_strobe_1clk", int'(pd), 0);
    repeat (60) @(negedge clk);
    chk("pulse5_single", pdcnt[2] - base, 1);

    // PULSE period 4 re-sent after 2 ticks: restart, single strobe.
    base = pdcnt[3];
    send_ph(cmd(3, 3, 4, 15));
    repeat (10) @(negedge clk);
    send_ph(cmd(3, 3, 4, 15));
    chk("pulse_resend_no_early_done", pdcnt[3] - base, 0);
    run(3, 1'b1, 39, "pulse_resend_len");
    repeat (50) @(negedge clk);
    chk("pulse_resend_single", pdcnt[3] - base, 1);

    // Period 0 behaves as period 1: toggles on every tick.
    send_ph(cmd(1, 2, 0, 15));
    run(1, 1'b1, 9, "p0_high0");
    run(1, 1'b0, 10, "p0_low");
    run(1, 1'b1, 10, "p0_high");

`ifdef LED_ARRAY_PWM_EN
    begin
      int n;
      send(cmd(0, 1, 1, 3));
      n = 0;
      repeat (16) begin
        if (q[0]) n++;
        @(negedge clk);
      end
      chk("pwm_duty3", n, 4);
      send(cmd(0, 1, 1, 15));
      n = 0;
      repeat (16) begin
        if (q[0]) n++;
        @(negedge clk);
      end
      chk("pwm_duty15", n, 16);
    end
`endif

    // Randomized traffic, including out-of-range channels and zero periods.
    for (int k = 0; k < 2500; k++) begin
      int ch;
      ch = $urandom_range(0, 5);
      if (ch == 5) ch = $urandom_range(4, 255);
      tvalid = ($urandom_range(0, 5) == 0);
      tdata  = {ch[7:0], 4'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                8'($urandom_range(0, 4))};
      @(negedge clk);
    end
    tvalid = 1'b0;

    // Asynchronous reset mid-operation.
    send(cmd(0, 1, 1, 15));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_pulse_done", int'(pd), 0);
    chk("async_rst_tready", int'(tready), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_tready", int'(tready), 1);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_array_ctrl.md
# led_array_ctrl

Parametrised multi-channel LED driver; the successor to the single-output fixed-rate board blinker. It drives `CHANNELS` independent LED outputs, each with a run-time mode (off, on, blink, one-shot pulse) and period, programmed through a 32-bit AXI-Stream-style command port. It sits between the board top level and any control logic or stream source, and derives a shared timebase tick from the board clock.

## Interface
- `CLK_FREQ_HZ`, 125_000_000, input clock frequency.
- `TICK_HZ`, 1000, timebase tick rate; `DIV = CLK_FREQ_HZ/TICK_HZ`, which must be ≥ 2.
- `CHANNELS`, 4, number of LED outputs, 1..256.
- `PERIOD_W`, 16, width of the per-channel period register, 1..16.

- `clk`  in  1  single clock domain.
- `rst_n`  in  1  asynchronous active-low reset; deassertion is synchronised to `clk` externally.
- `s_axis_tdata`  in  32  command word:
  - `[PERIOD_W-1:0]` period in ticks;
  - `[17:16]` mode: 0 OFF, 1 ON, 2 BLINK, 3 PULSE;
  - `[23:20]` duty, used only with PWM;
  - `[31:24]` channel index.
- `s_axis_tvalid`  in  1  command valid.
- `s_axis_tready`  out  1  command ready.
- `q`  out  CHANNELS  LED outputs, active high.
- `pulse_done`  out  CHANNELS  one-cycle strobe per channel when a PULSE completes.

## Operation
- Reset values:
  - `q` = 0, `pulse_done` = 0, `s_axis_tready` = 0.
  - Every channel: mode OFF, period 1, count 0, state 0, duty 15.
  - Prescaler count 0.
- `s_axis_tready` goes to 1 on the first clock after reset release and stays at 1. Command accept = `tvalid & tready` on a rising edge.
- Accepted command with channel index < `CHANNELS`:
  - load the channel's mode, period and duty;
  - count = 0;
  - state = 1 for ON, BLINK and PULSE; state = 0 for OFF.
- Index ≥ `CHANNELS`: the command is accepted and discarded, with no state change.
- Period 0 is stored as 1.
- Prescaler:
  - free-running counter 0..DIV-1;
  - `tick` is an internal one-cycle strobe when count == DIV-1;
  - commands never reset the prescaler.
- Per-channel behaviour on `tick`:
  - OFF and ON: no change.
  - BLINK: if count == period-1, toggle state and set count = 0; otherwise count+1. The output is a square wave with `period` ticks high and `period` ticks low.
  - PULSE: if count == period-1, set state = 0, mode = OFF and assert `pulse_done[ch]` for that cycle; otherwise count+1.
- Command and tick in the same cycle on the same channel: the command wins and that channel ignores the tick. Other channels process the tick normally.
- A new command mid-BLINK or mid-PULSE restarts the channel from count 0. An interrupted PULSE emits no `pulse_done`.
- Count and period arithmetic are unsigned `PERIOD_W` bits. The count never exceeds period-1, so it cannot wrap.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous).

## Timing
- Command latency: `q[ch]` reflects the new mode in the cycle after the accepting edge (registered output).
- BLINK or PULSE started at cycle T: the first state change occurs on the `period`-th tick after T; tick phase depends on the prescaler.
- `pulse_done[ch]` rises on the same edge where `q[ch]` falls at PULSE end. It lasts exactly 1 clock.
- Throughput: one command per clock.

## Configuration
- `LED_ARRAY_PWM_EN` defined:
  - a free-running 4-bit PWM counter `p` runs on `clk`;
  - `q[ch] = state[ch] & (p <= duty[ch])`;
  - duty 15 = 100%; duty 0 = 1/16 brightness.
  - The PWM counter resets to 0.
- Not defined:
  - `q[ch] = state[ch]`;
  - duty bits are ignored and no PWM logic is present.
- The macro does not affect mode/timing behaviour or the handshake.

## Test plan
Bench parameters for all scenarios: CLK_FREQ_HZ=100, TICK_HZ=10 (DIV=10), CHANNELS=4, PERIOD_W=8.

- Reset, then release: `q`=0, `pulse_done`=0, `tready`=0 during reset and 1 on the first clock after release.
- Send ch1 mode ON: `q`=4'b0010 one clock after accept. Then ch1 OFF: `q`=0 one clock after that accept.
- Send ch0 BLINK period 3: `q[0]` high 3 ticks (30 clks), low 3 ticks, repeating for ≥3 cycles. Other bits stay 0.
- Send ch2 PULSE period 5: `q[2]` high for 5 ticks, then 0. `pulse_done`=4'b0100 for exactly one clock on the falling edge; no further strobes.
- Corner commands:
  - ch3 PULSE period 4, re-sent after 2 ticks: pulse extends to 6 ticks total, with a single `pulse_done`.
  - command to ch index 7: no output change.
  - period 0 BLINK: toggles every tick.
- With `LED_ARRAY_PWM_EN`, ch0 ON duty 3: `q[0]` high 4 of every 16 clocks. With duty 15: constant high.
